// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter with bounded hold time
// and a registered 4:1 data mux driven by the current owner.
module rr_mux_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [4*DW-1:0] in,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] out,
  output logic          out_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] HOLD_MAX  = 4'(MAX_HOLD);
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t        state, state_d;
  logic [1:0]    ptr, ptr_d;
  logic [3:0]    cnt, cnt_d;
  logic [3:0]    gnt_d;
  logic [1:0]    sel_d;
  logic [DW-1:0] out_d;
  logic          vld_d;
  logic [3:0]    own;
  logic [3:0]    others;
  logic [DW-1:0] lane;
  logic          rotate;
  logic [2:0]    win;

  // First set bit of r scanning p, p+1, ... mod 4; msb flags a hit.
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Owner lane, competing requests and the forced-rotation condition.
  always_comb begin
    own    = 4'b0001 << sel;
    others = req & ~own;
    lane   = in[sel*DW +: DW];
    rotate = req[sel] && (cnt >= HOLD_LAST) && (|others);
  end

  // Next-state, pointer, hold counter and registered outputs.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    gnt_d   = gnt;
    sel_d   = sel;
    out_d   = out;
    vld_d   = 1'b0;
    win     = '0;
    unique case (state)
      IDLE: begin
        gnt_d = '0;
        win   = pick(req, ptr);
      end
      GRANT: begin
        if (req[sel]) begin
          out_d = lane;
          vld_d = 1'b1;
          if (cnt != HOLD_MAX) cnt_d = cnt + 4'd1;
          if (rotate) begin
            ptr_d = sel + 2'd1;
            win   = pick(others, sel + 2'd1);
          end
        end else begin
          ptr_d = sel + 2'd1;
          win   = pick(req, sel + 2'd1);
          if (!win[2]) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: ;
    endcase
    if (win[2]) begin
      state_d = GRANT;
      sel_d   = win[1:0];
      gnt_d   = 4'b0001 << win[1:0];
      cnt_d   = '0;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      sel       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      gnt       <= gnt_d;
      sel       <= sel_d;
      out       <= out_d;
      out_valid <= vld_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomised and directed bench for rr_mux_arbiter against a
// transfer-counting reference model.
module tb_rr_mux_arbiter;

  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = '0;
  logic [4*DW-1:0] in = '0;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] out;
  logic          out_valid;

  int checks = 0;
  int passed = 0;

  int            m_owner;
  int            m_ptr;
  int            m_held;
  logic [1:0]    m_sel;
  logic [DW-1:0] m_out;
  logic          m_vld;
  logic [3:0]    m_gnt;

  rr_mux_arbiter #(.DW(DW), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .in(in),
    .gnt(gnt),
    .sel(sel),
    .out(out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic int first_set(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = '0;
    m_out   = '0;
    m_vld   = 1'b0;
    m_gnt   = '0;
  endtask

  task automatic model_step();
    logic [3:0] others;
    if (m_owner < 0) begin
      m_vld = 1'b0;
      if (req != 0) begin
        m_owner = first_set(req, m_ptr);
        m_held  = 0;
      end
    end else if (req[m_owner]) begin
      m_out  = in[m_owner*DW +: DW];
      m_vld  = 1'b1;
      m_held = m_held + 1;
      others = req;
      others[m_owner] = 1'b0;
      if (m_held >= MH && others != 0) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = first_set(others, m_ptr);
        m_held  = 0;
      end
    end else begin
      m_vld   = 1'b0;
      m_ptr   = (m_owner + 1) % 4;
      m_owner = first_set(req, m_ptr);
      m_held  = 0;
    end
    if (m_owner >= 0) m_sel = m_owner[1:0];
    m_gnt = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    model_reset();
    checks++;
    if ({gnt, sel, out, out_valid} !== '0)
      $display("FAIL reset_async: gnt=%b sel=%0d out=%h v=%b want all 0",
               gnt, sel, out, out_valid);
    else passed++;
    req = 4'b1111;
    in  = $urandom;
    @(posedge clk);
    #1;
    checks++;
    if ({gnt, sel, out, out_valid} !== '0)
      $display("FAIL reset_held: gnt=%b sel=%0d out=%h v=%b want all 0",
               gnt, sel, out, out_valid);
    else passed++;
    req = '0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int vcnt;
    do_reset();
    vcnt = 0;
    req  = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      in = $urandom;
      in[1*DW +: DW] = 8'hA5;
      tick();
      if (out_valid) vcnt++;
      if (c == 0) begin
        checks++;
        if (gnt !== 4'b0010 || sel !== 2'd1)
          $display("FAIL single_grant: gnt=%b sel=%0d want 0010/1", gnt, sel);
        else passed++;
      end
      checks++;
      if ({gnt, sel, out, out_valid} !== {m_gnt, m_sel, m_out, m_vld})
        $display("FAIL single_cyc%0d: gnt=%b sel=%0d out=%h v=%b want %b %0d %h %b",
                 c, gnt, sel, out, out_valid, m_gnt, m_sel, m_out, m_vld);
      else passed++;
    end
    req = '0;
    tick();
    checks++;
    if (gnt !== 4'b0 || out_valid !== 1'b0 || out !== 8'hA5)
      $display("FAIL single_drop: gnt=%b v=%b out=%h want 0000 0 a5",
               gnt, out_valid, out);
    else passed++;
    checks++;
    if (vcnt !== 6)
      $display("FAIL single_vcount: got %0d want 6", vcnt);
    else passed++;
  endtask

  task automatic test_contention();
    int owners[$];
    int lens[$];
    int exp_o[5];
    int vcnt;
    logic [3:0] prev;
    exp_o = '{0, 1, 2, 3, 0};
    do_reset();
    vcnt = 0;
    prev = '0;
    req  = 4'b1111;
    for (int c = 0; c < 21; c++) begin
      in = $urandom;
      tick();
      if (c > 0 && out_valid) vcnt++;
      if (gnt != prev && gnt != 0) begin
        owners.push_back(first_set(gnt, 0));
        lens.push_back(1);
      end else if (lens.size() > 0) begin
        lens[lens.size()-1]++;
      end
      prev = gnt;
      checks++;
      if ({gnt, sel, out, out_valid} !== {m_gnt, m_sel, m_out, m_vld})
        $display("FAIL contend_cyc%0d: gnt=%b sel=%0d out=%h v=%b want %b %0d %h %b",
                 c, gnt, sel, out, out_valid, m_gnt, m_sel, m_out, m_vld);
      else passed++;
    end
    checks++;
    if (owners.size() < 5) begin
      $display("FAIL contend_order: only %0d grants want 5", owners.size());
    end else begin
      passed++;
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (owners[k] != exp_o[k])
          $display("FAIL contend_order%0d: got %0d want %0d", k, owners[k], exp_o[k]);
        else passed++;
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (lens[k] != MH)
          $display("FAIL contend_len%0d: got %0d want %0d", k, lens[k], MH);
        else passed++;
      end
    end
    checks++;
    if (vcnt != 20)
      $display("FAIL contend_gaps: valid cycles %0d want 20", vcnt);
    else passed++;
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      in = $urandom;
      tick();
    end
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || out_valid !== 1'b0)
      $display("FAIL early_release: gnt=%b v=%b want 0001 0", gnt, out_valid);
    else passed++;
    checks++;
    if ({gnt, sel, out, out_valid} !== {m_gnt, m_sel, m_out, m_vld})
      $display("FAIL early_model: gnt=%b sel=%0d out=%h v=%b want %b %0d %h %b",
               gnt, sel, out, out_valid, m_gnt, m_sel, m_out, m_vld);
    else passed++;
  endtask

  task automatic test_wrap();
    bit moved;
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b1001;
    moved = 0;
    for (int c = 0; c < 8 && !moved; c++) begin
      in = $urandom;
      tick();
      if (gnt != 4'b1000) moved = 1;
      checks++;
      if ({gnt, sel, out, out_valid} !== {m_gnt, m_sel, m_out, m_vld})
        $display("FAIL wrap_cyc%0d: gnt=%b sel=%0d out=%h v=%b want %b %0d %h %b",
                 c, gnt, sel, out, out_valid, m_gnt, m_sel, m_out, m_vld);
      else passed++;
    end
    checks++;
    if (gnt !== 4'b0001)
      $display("FAIL wrap_next: gnt=%b want 0001", gnt);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      in = $urandom;
      in[1*DW +: DW] = 8'h5A;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (gnt !== 4'b0 || out_valid !== 1'b0 || out !== '0)
      $display("FAIL async_abort: gnt=%b v=%b out=%h want 0000 0 00",
               gnt, out_valid, out);
    else passed++;
    req = 4'b0100;
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2)
      $display("FAIL async_regrant: gnt=%b sel=%0d want 0100/2", gnt, sel);
    else passed++;
  endtask

  task automatic test_isolation();
    logic [DW-1:0] l1;
    do_reset();
    req = 4'b0010;
    tick();
    for (int c = 0; c < 10; c++) begin
      in = $urandom;
      l1 = in[1*DW +: DW];
      tick();
      checks++;
      if (out !== l1 || out_valid !== 1'b1 || gnt !== 4'b0010)
        $display("FAIL isolate_cyc%0d: out=%h v=%b gnt=%b want %h 1 0010",
                 c, out, out_valid, gnt, l1);
      else passed++;
    end
  endtask

  task automatic test_starvation();
    int end_t[4];
    int worst[4];
    logic [3:0] prev;
    do_reset();
    req  = 4'b1111;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      end_t[i] = -1;
      worst[i] = 0;
    end
    for (int t = 0; t < 60; t++) begin
      in = $urandom;
      tick();
      for (int i = 0; i < 4; i++) begin
        if (prev[i] && !gnt[i]) end_t[i] = t;
        if (!prev[i] && gnt[i] && end_t[i] >= 0 && t - end_t[i] > worst[i])
          worst[i] = t - end_t[i];
      end
      prev = gnt;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (worst[i] < 1 || worst[i] > 3*MH)
        $display("FAIL starve_%0d: worst wait %0d want 1..%0d", i, worst[i], 3*MH);
      else passed++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      in = $urandom;
      tick();
      checks++;
      if ({gnt, sel, out, out_valid} !== {m_gnt, m_sel, m_out, m_vld})
        $display("FAIL random_cyc%0d: gnt=%b sel=%0d out=%h v=%b want %b %0d %h %b",
                 c, gnt, sel, out, out_valid, m_gnt, m_sel, m_out, m_vld);
      else passed++;
      checks++;
      if (gnt != 0 && gnt !== (4'b0001 << sel))
        $display("FAIL random_onehot%0d: gnt=%b sel=%0d", c, gnt, sel);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_wrap();
    test_async_reset();
    test_isolation();
    test_starvation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
